path_cost_sequencer: RTL and testbench

//  Timing/config controller in front of path_cost_calculator instances (horizontal, vertical, diagonal paths).

---
 rtl/path_cost_sequencer_pkg.sv | 32 +++
 rtl/path_cost_sequencer_shadow.sv | 45 ++++
 rtl/path_cost_sequencer.sv | 143 ++++++++++++++
 tb/tb_path_cost_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_cost_sequencer_pkg.sv
// rtl/path_cost_sequencer_pkg.sv - shared types, penalty constants and helpers for the path cost sequencer
package path_cost_sequencer_pkg;

   localparam int PEN_W = 8;
   localparam logic [PEN_W-1:0] P1_DEFAULT_C = 8'd8;
   localparam logic [PEN_W-1:0] P2_DEFAULT_C = 8'd32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LINE,
      ST_HBLANK
   } seq_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Counter width that never collapses to zero bits for tiny images.
   function automatic int bits_for(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

   // P2 is never allowed to fall below P1.
   function automatic logic [PEN_W-1:0] clamp_p2(input logic [PEN_W-1:0] p1,
                                                 input logic [PEN_W-1:0] p2);
      return (p2 < p1) ? p1 : p2;
   endfunction

endpackage

// File: rtl/path_cost_sequencer_shadow.sv
// rtl/path_cost_sequencer_shadow.sv - pending/active P1/P2 register pair, active copy updated only at frame start
module penalty_shadow_regs
   import path_cost_sequencer_pkg::*;
#(
   parameter logic [PEN_W-1:0] P1_DEFAULT = P1_DEFAULT_C,
   parameter logic [PEN_W-1:0] P2_DEFAULT = P2_DEFAULT_C
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_we_i,
   input  logic [PEN_W-1:0] p1_i,
   input  logic [PEN_W-1:0] p2_i,
   input  logic             frame_start_i,
   output logic [PEN_W-1:0] p1_o,
   output logic [PEN_W-1:0] p2_o
);

   logic [PEN_W-1:0] pend_p1_q, pend_p2_q;
   logic [PEN_W-1:0] act_p1_q, act_p2_q;
   logic [PEN_W-1:0] pend_p1_d, pend_p2_d;

   assign pend_p1_d = cfg_we_i ? p1_i : pend_p1_q;
   assign pend_p2_d = cfg_we_i ? clamp_p2(p1_i, p2_i) : pend_p2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_p1_q <= P1_DEFAULT;
         pend_p2_q <= P2_DEFAULT;
         act_p1_q  <= P1_DEFAULT;
         act_p2_q  <= P2_DEFAULT;
      end else begin
         pend_p1_q <= pend_p1_d;
         pend_p2_q <= pend_p2_d;
         // A write coincident with frame start takes effect for that frame.
         if (frame_start_i) begin
            act_p1_q <= pend_p1_d;
            act_p2_q <= pend_p2_d;
         end
      end
   end

   assign p1_o = act_p1_q;
   assign p2_o = act_p2_q;

endmodule

// File: rtl/path_cost_sequencer.sv
// rtl/path_cost_sequencer.sv - pixel position tracking, path-begin strobes and frame-stable penalties
module path_cost_sequencer
   import path_cost_sequencer_pkg::*;
#(
   parameter int IMG_WIDTH  = 1600,
   parameter int IMG_HEIGHT = 1200,
   parameter int P1_DEFAULT = 8,
   parameter int P2_DEFAULT = 32,
   localparam int X_BITS = bits_for(IMG_WIDTH),
   localparam int Y_BITS = bits_for(IMG_HEIGHT)
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_de,
   input  logic              in_frame_start,
   input  logic              in_cfg_we,
   input  logic [PEN_W-1:0]  in_P1,
   input  logic [PEN_W-1:0]  in_P2,
   output logic              out_ce,
   output logic              out_beg_h,
   output logic              out_beg_v,
   output logic              out_beg_d,
   output logic [X_BITS-1:0] out_x,
   output logic [Y_BITS-1:0] out_y,
   output logic [PEN_W-1:0]  out_P1,
   output logic [PEN_W-1:0]  out_P2,
   output logic              out_line_err,
   output logic              out_frame_done
);

   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_HEIGHT - 1);

   seq_state_t        state_q;
   logic [X_BITS-1:0] x_q;
   logic [Y_BITS-1:0] y_q;
   logic              full_q;
   logic              ce_q, beg_h_q, beg_v_q, err_q, done_q;
   logic [X_BITS-1:0] out_x_q;
   logic [Y_BITS-1:0] out_y_q;

   logic [X_BITS-1:0] cur_x_d;
   logic [Y_BITS-1:0] cur_y_d;
   logic              accept_d;

   // Frame start overrides the position so a coincident pixel lands on (0,0).
   assign cur_x_d  = in_frame_start ? '0 : x_q;
   assign cur_y_d  = in_frame_start ? '0 : y_q;
   assign accept_d = in_de && (in_frame_start || state_q == ST_HBLANK ||
                               (state_q == ST_LINE && !full_q));

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         full_q  <= 1'b0;
         ce_q    <= 1'b0;
         beg_h_q <= 1'b0;
         beg_v_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         out_x_q <= '0;
         out_y_q <= '0;
      end else begin
         ce_q    <= accept_d;
         beg_h_q <= accept_d && (cur_x_d == '0);
         beg_v_q <= accept_d && (cur_y_d == '0);
         done_q  <= 1'b0;

         if (in_frame_start) begin
            state_q <= ST_HBLANK;
            x_q     <= '0;
            y_q     <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
         end

         if (accept_d) begin
            out_x_q <= cur_x_d;
            out_y_q <= cur_y_d;
            state_q <= ST_LINE;
            if (cur_x_d == X_LAST) begin
               // Line complete; further pixels before de falls are rejected.
               x_q    <= '0;
               full_q <= 1'b1;
               if (cur_y_d == Y_LAST) begin
                  state_q <= ST_IDLE;
                  y_q     <= '0;
                  done_q  <= 1'b1;
               end else begin
                  y_q <= cur_y_d + 1'b1;
               end
            end else begin
               x_q <= cur_x_d + 1'b1;
            end
         end else if (!in_frame_start && state_q == ST_LINE) begin
            if (in_de) begin
               err_q <= 1'b1;
            end else begin
               state_q <= ST_HBLANK;
               full_q  <= 1'b0;
               // Short line still advances the row to keep the delay line aligned.
               if (!full_q && x_q != '0) begin
                  err_q <= 1'b1;
                  x_q   <= '0;
                  if (y_q == Y_LAST) begin
                     state_q <= ST_IDLE;
                     y_q     <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     y_q <= y_q + 1'b1;
                  end
               end
            end
         end
      end
   end

   penalty_shadow_regs #(
      .P1_DEFAULT(PEN_W'(P1_DEFAULT)),
      .P2_DEFAULT(PEN_W'(P2_DEFAULT))
   ) u_shadow (
      .clk_i        (in_clk),
      .rst_i        (in_rst),
      .cfg_we_i     (in_cfg_we),
      .p1_i         (in_P1),
      .p2_i         (in_P2),
      .frame_start_i(in_frame_start),
      .p1_o         (out_P1),
      .p2_o         (out_P2)
   );

   assign out_ce         = ce_q;
   assign out_beg_h      = beg_h_q;
   assign out_beg_v      = beg_v_q;
   assign out_beg_d      = beg_h_q | beg_v_q;
   assign out_x          = out_x_q;
   assign out_y          = out_y_q;
   assign out_line_err   = err_q;
   assign out_frame_done = done_q;

endmodule

// File: tb/tb_path_cost_sequencer.sv
// tb/tb_path_cost_sequencer.sv - directed self-checking bench for path_cost_sequencer (4x3 image)
module tb_path_cost_sequencer;

   logic       in_clk = 1'b0;
   logic       in_rst = 1'b1;
   logic       in_de = 1'b0;
   logic       in_frame_start = 1'b0;
   logic       in_cfg_we = 1'b0;
   logic [7:0] in_P1 = 8'd0;
   logic [7:0] in_P2 = 8'd0;
   logic       out_ce, out_beg_h, out_beg_v, out_beg_d, out_line_err, out_frame_done;
   logic [1:0] out_x;
   logic [1:0] out_y;
   logic [7:0] out_P1, out_P2;

   int total = 0;
   int bad = 0;

   path_cost_sequencer #(
      .IMG_WIDTH(4), .IMG_HEIGHT(3), .P1_DEFAULT(8), .P2_DEFAULT(32)
   ) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_de(in_de), .in_frame_start(in_frame_start),
      .in_cfg_we(in_cfg_we), .in_P1(in_P1), .in_P2(in_P2),
      .out_ce(out_ce), .out_beg_h(out_beg_h), .out_beg_v(out_beg_v), .out_beg_d(out_beg_d),
      .out_x(out_x), .out_y(out_y), .out_P1(out_P1), .out_P2(out_P2),
      .out_line_err(out_line_err), .out_frame_done(out_frame_done)
   );

   always #5 in_clk = ~in_clk;

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic pulse_frame_start();
      in_frame_start = 1'b1;
      step();
      in_frame_start = 1'b0;
   endtask

   task automatic run_line(input int n);
      in_de = 1'b1;
      repeat (n) step();
      in_de = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [23:0] got;
      in_rst = 1'b1;
      step();
      in_rst = 1'b0;
      step();
      got = {out_ce, out_beg_h, out_beg_v, out_beg_d, out_x, out_y, out_line_err, out_frame_done, out_P1, out_P2};
      total++;
      if (got !== {4'b0, 2'd0, 2'd0, 2'b0, 8'd8, 8'd32}) begin
         bad++;
         $display("FAIL reset_state got=%h exp=%h", got, {4'b0, 2'd0, 2'd0, 2'b0, 8'd8, 8'd32});
      end
      // Load non-default penalties, make an error, then reset mid-frame.
      in_cfg_we = 1'b1; in_P1 = 8'd50; in_P2 = 8'd60;
      pulse_frame_start();
      in_cfg_we = 1'b0;
      run_line(2);
      in_de = 1'b1;
      step();
      total++;
      if ({out_P1, out_P2, out_line_err, out_ce} !== {8'd50, 8'd60, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset got=%h exp=%h", {out_P1, out_P2, out_line_err, out_ce}, {8'd50, 8'd60, 1'b1, 1'b1});
      end
      #2 in_rst = 1'b1;
      #1;
      got = {out_ce, out_beg_h, out_beg_v, out_beg_d, out_x, out_y, out_line_err, out_frame_done, out_P1, out_P2};
      total++;
      if (got !== {4'b0, 2'd0, 2'd0, 2'b0, 8'd8, 8'd32}) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", got, {4'b0, 2'd0, 2'd0, 2'b0, 8'd8, 8'd32});
      end
      #1 in_rst = 1'b0;
      step();
      total++;
      if (out_ce !== 1'b0) begin
         bad++;
         $display("FAIL idle_ignores_de got=%b exp=0", out_ce);
      end
      in_de = 1'b0;
      step();
   endtask

   task automatic test_frame();
      logic [10:0] got, exp;
      int budget;
      pulse_frame_start();
      for (int l = 0; l < 3; l++) begin
         for (int x = 0; x < 4; x++) begin
            in_de = 1'b1;
            step();
            got = {out_ce, out_beg_h, out_beg_v, out_beg_d, out_frame_done, out_x, out_y, out_line_err};
            exp = {1'b1, x == 0, l == 0, (x == 0) || (l == 0), (l == 2) && (x == 3), 2'(x), 2'(l), 1'b0};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL frame_px l=%0d x=%0d got=%h exp=%h", l, x, got, exp);
            end
         end
         in_de = 1'b0;
         repeat (2) begin
            step();
            total++;
            if ({out_ce, out_frame_done} !== 2'b00) begin
               bad++;
               $display("FAIL hblank l=%0d got=%b exp=00", l, {out_ce, out_frame_done});
            end
         end
      end
      in_de = 1'b1;
      budget = 0;
      repeat (3) begin
         step();
         if (out_ce) budget++;
      end
      in_de = 1'b0;
      step();
      total++;
      if (budget !== 0) begin
         bad++;
         $display("FAIL after_frame_ce got=%0d exp=0", budget);
      end
   endtask

   task automatic test_short_line();
      pulse_frame_start();
      run_line(3);
      total++;
      if (out_line_err !== 1'b1) begin
         bad++;
         $display("FAIL short_err got=%b exp=1", out_line_err);
      end
      in_de = 1'b1;
      step();
      total++;
      if ({out_ce, out_x, out_y, out_beg_h, out_beg_v} !== {1'b1, 2'd0, 2'd1, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL short_next got=%b exp=%b", {out_ce, out_x, out_y, out_beg_h, out_beg_v}, {1'b1, 2'd0, 2'd1, 1'b1, 1'b0});
      end
      in_de = 1'b0;
      step();
      pulse_frame_start();
      total++;
      if (out_line_err !== 1'b0) begin
         bad++;
         $display("FAIL short_err_clear got=%b exp=0", out_line_err);
      end
   endtask

   task automatic test_long_line();
      int ce_cnt;
      ce_cnt = 0;
      in_de = 1'b1;
      repeat (6) begin
         step();
         if (out_ce) ce_cnt++;
      end
      total++;
      if (ce_cnt !== 4) begin
         bad++;
         $display("FAIL long_ce_count got=%0d exp=4", ce_cnt);
      end
      total++;
      if (out_line_err !== 1'b1) begin
         bad++;
         $display("FAIL long_err got=%b exp=1", out_line_err);
      end
      in_de = 1'b0;
      step();
      in_de = 1'b1;
      step();
      total++;
      if ({out_ce, out_x, out_y} !== {1'b1, 2'd0, 2'd1}) begin
         bad++;
         $display("FAIL long_resume got=%b exp=%b", {out_ce, out_x, out_y}, {1'b1, 2'd0, 2'd1});
      end
      in_de = 1'b0;
      step();
   endtask

   task automatic test_cfg();
      in_cfg_we = 1'b1; in_P1 = 8'd10; in_P2 = 8'd40;
      step();
      in_cfg_we = 1'b0;
      run_line(2);
      total++;
      if ({out_P1, out_P2} !== {8'd8, 8'd32}) begin
         bad++;
         $display("FAIL cfg_hold got=%0d/%0d exp=8/32", out_P1, out_P2);
      end
      pulse_frame_start();
      total++;
      if ({out_P1, out_P2} !== {8'd10, 8'd40}) begin
         bad++;
         $display("FAIL cfg_apply got=%0d/%0d exp=10/40", out_P1, out_P2);
      end
      in_cfg_we = 1'b1; in_P1 = 8'd20; in_P2 = 8'd5;
      step();
      in_cfg_we = 1'b0;
      total++;
      if ({out_P1, out_P2} !== {8'd10, 8'd40}) begin
         bad++;
         $display("FAIL cfg_clamp_hold got=%0d/%0d exp=10/40", out_P1, out_P2);
      end
      pulse_frame_start();
      total++;
      if ({out_P1, out_P2} !== {8'd20, 8'd20}) begin
         bad++;
         $display("FAIL cfg_clamp got=%0d/%0d exp=20/20", out_P1, out_P2);
      end
      in_cfg_we = 1'b1; in_P1 = 8'd3; in_P2 = 8'd7;
      pulse_frame_start();
      in_cfg_we = 1'b0;
      total++;
      if ({out_P1, out_P2} !== {8'd3, 8'd7}) begin
         bad++;
         $display("FAIL cfg_coincident got=%0d/%0d exp=3/7", out_P1, out_P2);
      end
   endtask

   task automatic test_fs_coincident();
      pulse_frame_start();
      run_line(4);
      run_line(3);
      total++;
      if (out_line_err !== 1'b1) begin
         bad++;
         $display("FAIL fs_pre_err got=%b exp=1", out_line_err);
      end
      in_frame_start = 1'b1;
      in_de = 1'b1;
      step();
      in_frame_start = 1'b0;
      total++;
      if ({out_ce, out_x, out_y, out_beg_h, out_beg_v, out_beg_d, out_line_err} !== {1'b1, 2'd0, 2'd0, 3'b111, 1'b0}) begin
         bad++;
         $display("FAIL fs_coincident got=%b exp=%b", {out_ce, out_x, out_y, out_beg_h, out_beg_v, out_beg_d, out_line_err}, {1'b1, 2'd0, 2'd0, 3'b111, 1'b0});
      end
      for (int x = 1; x < 4; x++) begin
         step();
         total++;
         if ({out_ce, out_x, out_y, out_beg_h, out_beg_v} !== {1'b1, 2'(x), 2'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL fs_follow x=%0d got=%b exp=%b", x, {out_ce, out_x, out_y, out_beg_h, out_beg_v}, {1'b1, 2'(x), 2'd0, 1'b0, 1'b1});
         end
      end
      in_de = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_frame();
      test_short_line();
      test_long_line();
      test_cfg();
      test_fs_coincident();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
